// File: rtl/mips_multicycle_datapath.sv
// Multicycle MIPS-32 datapath: PC, ROM/RAM/GPIO memory system, IR, MDR, register file,
// A/B/ALUOut registers and ALU. Steered cycle by cycle by an external control FSM.
// The ROM image comes in through the ROM_INIT parameter, so the ROM is a pure constant table.
module mips_multicycle_datapath #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] DATA_BASE = 32'h1001_0000,
  parameter logic [31:0] GPIO_ADDR = 32'h1001_0024,
  parameter int unsigned ROM_WORDS = 64,
  parameter int unsigned RAM_WORDS = 64,
  parameter logic [31:0] ROM_INIT [ROM_WORDS] = '{default: 32'h0}
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_PC,
  input  logic        Selector_Addr,
  input  logic        enable_MemSys,
  input  logic        enable_RegIns,
  input  logic        enable_RF,
  input  logic        Selector_RF_WR,
  input  logic        Selector_RF_WD,
  input  logic        Selector_ALU_Src_A,
  input  logic [1:0]  Selector_ALU_Src_B,
  input  logic        Selector_PC_Source,
  input  logic [2:0]  Selector_ALU_Op,
  output logic [31:0] Reg_Inst_o,
  output logic [31:0] Program_Counter_o,
  output logic [31:0] RegFile_A_o,
  output logic [31:0] RegFile_B_o,
  output logic [31:0] Sign_Ext_o,
  output logic [4:0]  Mux_WR_o,
  output logic [31:0] Mux_WD_o,
  output logic [31:0] Mux_A_o,
  output logic [31:0] Mux_B_o,
  output logic [31:0] ALU_Result_o,
  output logic [7:0]  GPIO_o
);

  typedef enum logic [2:0] {
    ALU_AND   = 3'b000,
    ALU_ADD   = 3'b001,
    ALU_SUB   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_SLT   = 3'b100,
    ALU_NOR   = 3'b101,
    ALU_XOR   = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;

  localparam int unsigned ROM_AW = $clog2(ROM_WORDS);
  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

  logic [31:0] pc, ir, mdr, a_reg, b_reg, alu_out;
  logic [31:0] mem_addr, mem_rd, rom_word, ram_word;
  logic [31:0] sign_ext, mux_a, mux_b, mux_wd, alu_result, next_pc;
  logic [4:0]  mux_wr;
  logic [7:0]  gpio;
  logic        ram_we;
  logic [31:0] rf  [32];
  logic [31:0] ram [RAM_WORDS];

  assign mem_addr = Selector_Addr ? alu_out : pc;
  assign rom_word = (mem_addr - RESET_PC) >> 2;
  assign ram_word = (mem_addr - DATA_BASE) >> 2;

  // Top nibble zero selects the instruction ROM; everything else is RAM space.
  always_comb begin
    mem_rd = '0;
    if (mem_addr[31:28] == 4'h0) begin
      if (rom_word < ROM_WORDS) mem_rd = ROM_INIT[rom_word[ROM_AW-1:0]];
    end else if (ram_word < RAM_WORDS) begin
      mem_rd = ram[ram_word[RAM_AW-1:0]];
    end
  end

  // The GPIO address shadows its RAM word: such stores never reach RAM.
  assign ram_we = enable_MemSys && (mem_addr != GPIO_ADDR) &&
                  (mem_addr[31:28] != 4'h0) && (ram_word < RAM_WORDS);

  assign sign_ext = {{16{ir[15]}}, ir[15:0]};
  assign mux_wr   = Selector_RF_WR ? ir[15:11] : ir[20:16];
  assign mux_wd   = Selector_RF_WD ? mdr : alu_out;
  assign mux_a    = Selector_ALU_Src_A ? a_reg : pc;

  always_comb begin
    mux_b = b_reg;
    case (Selector_ALU_Src_B)
      2'b00: mux_b = b_reg;
      2'b01: mux_b = 32'd4;
      2'b10: mux_b = sign_ext;
      2'b11: mux_b = {sign_ext[29:0], 2'b00};
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_op_e'(Selector_ALU_Op))
      ALU_AND:   alu_result = mux_a & mux_b;
      ALU_ADD:   alu_result = mux_a + mux_b;
      ALU_SUB:   alu_result = mux_a - mux_b;
      ALU_OR:    alu_result = mux_a | mux_b;
      ALU_SLT:   alu_result = {31'b0, $signed(mux_a) < $signed(mux_b)};
      ALU_NOR:   alu_result = ~(mux_a | mux_b);
      ALU_XOR:   alu_result = mux_a ^ mux_b;
      ALU_PASSB: alu_result = mux_b;
    endcase
  end

  assign next_pc = Selector_PC_Source ? alu_out : alu_result;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      gpio    <= '0;
      rf      <= '{default: 32'h0};
    end else begin
      if (enable_PC)     pc <= next_pc;
      if (enable_RegIns) ir <= mem_rd;
      mdr     <= mem_rd;
      a_reg   <= (ir[25:21] == 5'd0) ? '0 : rf[ir[25:21]];
      b_reg   <= (ir[20:16] == 5'd0) ? '0 : rf[ir[20:16]];
      alu_out <= alu_result;
      if (enable_MemSys && (mem_addr == GPIO_ADDR)) gpio <= b_reg[7:0];
      if (enable_RF && (mux_wr != 5'd0))            rf[mux_wr] <= mux_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && ram_we) ram[ram_word[RAM_AW-1:0]] <= b_reg;
  end

  assign Reg_Inst_o        = ir;
  assign Program_Counter_o = pc;
  assign RegFile_A_o       = a_reg;
  assign RegFile_B_o       = b_reg;
  assign Sign_Ext_o        = sign_ext;
  assign Mux_WR_o          = mux_wr;
  assign Mux_WD_o          = mux_wd;
  assign Mux_A_o           = mux_a;
  assign Mux_B_o           = mux_b;
  assign ALU_Result_o      = alu_result;
  assign GPIO_o            = gpio;

endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// Directed bench for mips_multicycle_datapath: steps a small program through
// fetch/decode/execute/memory/writeback cycles and checks hand-computed node values.
module tb_mips_multicycle_datapath;

  localparam logic [31:0] PROG [64] = '{
    0:  32'h2008_0005,  // addi $t0,$0,5
    1:  32'h2009_0007,  // addi $t1,$0,7
    2:  32'h0109_5020,  // add  $t2,$t0,$t1
    3:  32'h8C10_0030,  // lw   $s0 (PC-relative to ROM[16])
    4:  32'h8C11_0030,  // lw   $s1 (PC-relative to ROM[17])
    5:  32'hAE0A_0020,  // sw   $t2,0x20($s0)
    6:  32'hAE11_0024,  // sw   $s1,0x24($s0) -> GPIO
    7:  32'h8E0B_0020,  // lw   $t3,0x20($s0)
    8:  32'h2000_0063,  // addi $0,$0,99
    9:  32'h200D_FFFD,  // addi $t5,$0,-3
    16: 32'h1001_0000,
    17: 32'h1234_56A5,
    default: 32'h0
  };

  localparam logic [31:0] ALU_EXP [8] = '{
    32'h0000_0005, 32'h0000_000C, 32'hFFFF_FFFE, 32'h0000_0007,
    32'h0000_0001, 32'hFFFF_FFF8, 32'h0000_0002, 32'h0000_0007
  };

  logic        clk, reset;
  logic        enable_PC, Selector_Addr, enable_MemSys, enable_RegIns, enable_RF;
  logic        Selector_RF_WR, Selector_RF_WD, Selector_ALU_Src_A, Selector_PC_Source;
  logic [1:0]  Selector_ALU_Src_B;
  logic [2:0]  Selector_ALU_Op;
  logic [31:0] Reg_Inst_o, Program_Counter_o, RegFile_A_o, RegFile_B_o, Sign_Ext_o;
  logic [31:0] Mux_WD_o, Mux_A_o, Mux_B_o, ALU_Result_o;
  logic [4:0]  Mux_WR_o;
  logic [7:0]  GPIO_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_pc;

  mips_multicycle_datapath #(.ROM_INIT(PROG)) dut (
    .clk(clk), .reset(reset), .enable_PC(enable_PC), .Selector_Addr(Selector_Addr),
    .enable_MemSys(enable_MemSys), .enable_RegIns(enable_RegIns), .enable_RF(enable_RF),
    .Selector_RF_WR(Selector_RF_WR), .Selector_RF_WD(Selector_RF_WD),
    .Selector_ALU_Src_A(Selector_ALU_Src_A), .Selector_ALU_Src_B(Selector_ALU_Src_B),
    .Selector_PC_Source(Selector_PC_Source), .Selector_ALU_Op(Selector_ALU_Op),
    .Reg_Inst_o(Reg_Inst_o), .Program_Counter_o(Program_Counter_o),
    .RegFile_A_o(RegFile_A_o), .RegFile_B_o(RegFile_B_o), .Sign_Ext_o(Sign_Ext_o),
    .Mux_WR_o(Mux_WR_o), .Mux_WD_o(Mux_WD_o), .Mux_A_o(Mux_A_o), .Mux_B_o(Mux_B_o),
    .ALU_Result_o(ALU_Result_o), .GPIO_o(GPIO_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    enable_PC = 0; Selector_Addr = 0; enable_MemSys = 0; enable_RegIns = 0; enable_RF = 0;
    Selector_RF_WR = 0; Selector_RF_WD = 0; Selector_ALU_Src_A = 0;
    Selector_ALU_Src_B = 2'b00; Selector_PC_Source = 0; Selector_ALU_Op = 3'b000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] ir_exp);
    idle();
    enable_PC = 1; enable_RegIns = 1; Selector_ALU_Src_B = 2'b01; Selector_ALU_Op = 3'b001;
    #1;
    check({tag, "_npc"}, ALU_Result_o, exp_pc + 32'd4);
    tick();
    exp_pc = exp_pc + 32'd4;
    check({tag, "_ir"}, Reg_Inst_o, ir_exp);
    check({tag, "_pc"}, Program_Counter_o, exp_pc);
    idle();
  endtask

  task automatic decode();
    idle();
    tick();
  endtask

  task automatic exec(input string tag, input logic src_a, input logic [1:0] src_b,
                      input logic [31:0] alu_exp);
    idle();
    Selector_ALU_Src_A = src_a; Selector_ALU_Src_B = src_b; Selector_ALU_Op = 3'b001;
    #1;
    check({tag, "_alu"}, ALU_Result_o, alu_exp);
    tick();
    idle();
  endtask

  task automatic mem(input logic we);
    idle();
    Selector_Addr = 1; enable_MemSys = we;
    #1;
    tick();
    idle();
  endtask

  task automatic wb(input string tag, input logic sel_wr, input logic sel_wd,
                    input logic [4:0] wr_exp, input logic [31:0] wd_exp);
    idle();
    enable_RF = 1; Selector_RF_WR = sel_wr; Selector_RF_WD = sel_wd;
    #1;
    check({tag, "_wr"}, {27'b0, Mux_WR_o}, {27'b0, wr_exp});
    check({tag, "_wd"}, Mux_WD_o, wd_exp);
    tick();
    idle();
  endtask

  initial begin
    reset = 0;
    idle();
    tick();
    check("rst_pc", Program_Counter_o, 32'h0040_0000);
    check("rst_a", RegFile_A_o, 32'h0);
    check("rst_b", RegFile_B_o, 32'h0);
    check("rst_gpio", {24'b0, GPIO_o}, 32'h0);
    check("rst_ir", Reg_Inst_o, 32'h0);
    reset = 1;
    tick();
    check("hold_pc", Program_Counter_o, 32'h0040_0000);
    exp_pc = 32'h0040_0000;

    fetch("i0", PROG[0]);
    decode();
    check("i0_sext", Sign_Ext_o, 32'h5);
    exec("i0", 1'b1, 2'b10, 32'h5);
    wb("i0", 1'b0, 1'b0, 5'd8, 32'h5);
    check("wtr_old", RegFile_B_o, 32'h0);

    fetch("i1", PROG[1]);
    check("wtr_new", RegFile_B_o, 32'h5);
    decode();
    exec("i1", 1'b1, 2'b10, 32'h7);
    wb("i1", 1'b0, 1'b0, 5'd9, 32'h7);

    fetch("i2", PROG[2]);
    decode();
    check("i2_a", RegFile_A_o, 32'h5);
    check("i2_b", RegFile_B_o, 32'h7);
    Selector_ALU_Src_A = 1; Selector_ALU_Src_B = 2'b00;
    for (int i = 0; i < 8; i++) begin
      Selector_ALU_Op = 3'(i);
      #1;
      check($sformatf("alu_op%0d", i), ALU_Result_o, ALU_EXP[i]);
    end
    Selector_ALU_Src_B = 2'b11;
    #1;
    check("srcb_sl2", Mux_B_o, 32'h0001_4080);
    Selector_ALU_Src_B = 2'b01;
    #1;
    check("srcb_4", Mux_B_o, 32'h4);
    exec("i2", 1'b1, 2'b00, 32'hC);
    wb("i2", 1'b1, 1'b0, 5'd10, 32'hC);

    fetch("i3", PROG[3]);
    decode();
    exec("i3", 1'b0, 2'b10, 32'h0040_0040);
    mem(1'b0);
    wb("i3", 1'b0, 1'b1, 5'd16, 32'h1001_0000);

    fetch("i4", PROG[4]);
    decode();
    exec("i4", 1'b0, 2'b10, 32'h0040_0044);
    mem(1'b0);
    wb("i4", 1'b0, 1'b1, 5'd17, 32'h1234_56A5);

    fetch("i5", PROG[5]);
    decode();
    check("i5_a", RegFile_A_o, 32'h1001_0000);
    check("i5_b", RegFile_B_o, 32'hC);
    exec("i5", 1'b1, 2'b10, 32'h1001_0020);
    mem(1'b1);

    fetch("i6", PROG[6]);
    decode();
    check("i6_b", RegFile_B_o, 32'h1234_56A5);
    exec("i6", 1'b1, 2'b10, 32'h1001_0024);
    mem(1'b1);
    check("gpio", {24'b0, GPIO_o}, 32'hA5);

    fetch("i7", PROG[7]);
    decode();
    exec("i7", 1'b1, 2'b10, 32'h1001_0020);
    mem(1'b0);
    wb("ram_kept", 1'b0, 1'b1, 5'd11, 32'hC);

    fetch("i8", PROG[8]);
    decode();
    exec("i8", 1'b1, 2'b10, 32'h63);
    wb("i8", 1'b0, 1'b0, 5'd0, 32'h63);
    tick();
    check("r0_a", RegFile_A_o, 32'h0);
    check("r0_b", RegFile_B_o, 32'h0);

    fetch("i9", PROG[9]);
    decode();
    check("i9_sext", Sign_Ext_o, 32'hFFFF_FFFD);
    Selector_ALU_Src_A = 1; Selector_ALU_Src_B = 2'b10; Selector_ALU_Op = 3'b100;
    #1;
    check("slt_signed", ALU_Result_o, 32'h0);
    Selector_ALU_Op = 3'b010;
    #1;
    check("sub_neg", ALU_Result_o, 32'h3);
    exec("br", 1'b0, 2'b11, 32'h0040_001C);
    enable_PC = 1; Selector_PC_Source = 1; Selector_ALU_Src_B = 2'b01; Selector_ALU_Op = 3'b001;
    #1;
    check("br_comb", ALU_Result_o, 32'h0040_002C);
    tick();
    idle();
    check("br_pc", Program_Counter_o, 32'h0040_001C);
    exp_pc = 32'h0040_001C;
    fetch("br_tgt", PROG[7]);

    reset = 0;
    tick();
    check("mid_rst_pc", Program_Counter_o, 32'h0040_0000);
    check("mid_rst_gpio", {24'b0, GPIO_o}, 32'h0);
    check("mid_rst_ir", Reg_Inst_o, 32'h0);
    check("mid_rst_a", RegFile_A_o, 32'h0);
    reset = 1;
    tick();
    check("post_rst_pc", Program_Counter_o, 32'h0040_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
